// File: rtl/nec_uart_sched_if.sv
// Handshake bundle between the NEC/BCD front end, the sequencer and the UART transmitter.
// The sequencer takes the slave side; whatever drives BCD pushes and accepts bytes takes the master side.
interface nec_uart_sched_if;
  logic [11:0] bcd_in;
  logic        bcd_in_en;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (
    output bcd_in,
    output bcd_in_en,
    output tx_ready,
    input  tx_data,
    input  tx_valid
  );

  modport slave (
    input  bcd_in,
    input  bcd_in_en,
    input  tx_ready,
    output tx_data,
    output tx_valid
  );
endinterface

// File: rtl/nec_uart_sched.sv
// Queues BCD results in a small FIFO and streams each one to the UART as an ASCII digit string,
// optionally terminated by CR LF, over a valid/ready handshake.
module nec_uart_sched #(
  parameter int DEPTH         = 4,
  parameter int ZERO_SUPPRESS = 1,
  parameter int EOL_EN        = 1
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  nec_uart_sched_if.slave    bus,
  output logic               busy,
  output logic [7:0]         drop_cnt
);

  localparam int          AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic {S_IDLE, S_SEND} state_t;

  function automatic logic [7:0] digit_char(input logic [3:0] d);
    return (d > 4'd9) ? 8'h3F : (8'h30 + {4'h0, d});
  endfunction

  logic [11:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          push;
  logic          pop;
  logic          drop;
  logic          accept;

  state_t        state;
  state_t        state_d;
  logic [2:0]    idx;
  logic [2:0]    last_idx;
  logic [7:0]    chars [8];
  logic [7:0]    new_chars [8];
  logic [2:0]    new_last;

  // A full FIFO refuses the push even when a pop frees a slot in the same cycle.
  assign push = bus.bcd_in_en && (count != FULL);
  assign drop = bus.bcd_in_en && (count == FULL);
  assign busy = (state == S_SEND) || (count != '0);

  always_comb begin
    state_d      = state;
    pop          = 1'b0;
    accept       = 1'b0;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    case (state)
      S_IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = S_SEND;
        end
      end
      S_SEND: begin
        bus.tx_valid = 1'b1;
        bus.tx_data  = chars[idx];
        accept       = bus.tx_ready;
        if (accept && (idx == last_idx)) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Build the outgoing string from the FIFO head; a non-decimal nibble never counts as a zero.
  always_comb begin
    logic [11:0] head;
    logic [2:0]  n;
    logic        show_h;
    logic        show_t;
    head   = mem[rd_ptr];
    show_h = (ZERO_SUPPRESS == 0) || (head[11:8] != 4'h0);
    show_t = show_h || (head[7:4] != 4'h0);
    for (int i = 0; i < 8; i++) begin
      new_chars[i] = 8'h00;
    end
    n = 3'd0;
    if (show_h) begin
      new_chars[n] = digit_char(head[11:8]);
      n            = n + 3'd1;
    end
    if (show_t) begin
      new_chars[n] = digit_char(head[7:4]);
      n            = n + 3'd1;
    end
    new_chars[n] = digit_char(head[3:0]);
    n            = n + 3'd1;
    if (EOL_EN != 0) begin
      new_chars[n] = 8'h0D;
      n            = n + 3'd1;
      new_chars[n] = 8'h0A;
      n            = n + 3'd1;
    end
    new_last = n - 3'd1;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state    <= S_IDLE;
      idx      <= 3'd0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= 8'd0;
    end else begin
      state <= state_d;
      if (pop) begin
        idx <= 3'd0;
      end else if (accept) begin
        idx <= idx + 3'd1;
      end
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && (drop_cnt != 8'hFF)) begin
        drop_cnt <= drop_cnt + 8'd1;
      end
    end
  end

  // Payload storage carries no reset; tx_data is forced to zero outside S_SEND instead.
  always_ff @(posedge sys_clk) begin
    if (push) begin
      mem[wr_ptr] <= bus.bcd_in;
    end
    if (pop) begin
      chars    <= new_chars;
      last_idx <= new_last;
    end
  end

endmodule

// File: tb/tb_nec_uart_sched.sv
// Bench for nec_uart_sched: directed scenarios plus randomized bursts, scored against a string-level model.
module tb_nec_uart_sched;
  logic       sys_clk = 1'b0;
  logic       sys_rst_n;
  logic       busy;
  logic [7:0] drop_cnt;

  nec_uart_sched_if bus ();

  nec_uart_sched #(
    .DEPTH(4),
    .ZERO_SUPPRESS(1),
    .EOL_EN(1)
  ) dut (
    .sys_clk(sys_clk),
    .sys_rst_n(sys_rst_n),
    .bus(bus.slave),
    .busy(busy),
    .drop_cnt(drop_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data  = 8'h00;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [11:0] v);
    bus.bcd_in    = v;
    bus.bcd_in_en = 1'b1;
    tick();
    bus.bcd_in_en = 1'b0;
  endtask

  // Reference: one string per value, leading zeros dropped, ones digit always kept.
  function automatic void add_exp(input logic [11:0] v);
    logic [3:0] dg [3];
    int         first;
    dg[0] = v[11:8];
    dg[1] = v[7:4];
    dg[2] = v[3:0];
    first = 0;
    while (first < 2 && dg[first] == 4'd0) first++;
    for (int k = first; k < 3; k++) begin
      exp_q.push_back((dg[k] <= 4'd9) ? (8'h30 + {4'h0, dg[k]}) : 8'h3F);
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endfunction

  task automatic wait_valid();
    int k = 0;
    while (!bus.tx_valid && k < 20) begin
      tick();
      k++;
    end
    chk("wait_valid", 32'(bus.tx_valid), 32'd1);
  endtask

  task automatic drain(input bit rand_ready);
    int k = 0;
    int n;
    while ((busy || bus.tx_valid) && k < 3000) begin
      if (rand_ready) bus.tx_ready = 1'($urandom_range(0, 1));
      tick();
      k++;
    end
    bus.tx_ready = 1'b1;
    chk("drain_timeout", 32'(k < 3000), 32'd1);
    chk("stream_len", 32'(got_q.size()), 32'(exp_q.size()));
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("byte%0d", i), 32'(got_q[i]), 32'(exp_q[i]));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  // Byte collector and handshake-stability watcher, sampled on the falling edge.
  always @(negedge sys_clk) begin
    if (prev_stall) begin
      chk("hold_valid", 32'(bus.tx_valid), 32'd1);
      chk("hold_data", 32'(bus.tx_data), 32'(prev_data));
    end
    if (sys_rst_n && bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
    prev_stall = sys_rst_n && bus.tx_valid && !bus.tx_ready;
    prev_data  = bus.tx_data;
  end

  initial begin
    logic [8:0]  seq [9];
    logic [11:0] vals [6];
    logic [11:0] v;
    int          n;

    sys_rst_n     = 1'b0;
    bus.bcd_in    = 12'h000;
    bus.bcd_in_en = 1'b0;
    bus.tx_ready  = 1'b1;
    repeat (3) tick();
    chk("rst_valid", 32'(bus.tx_valid), 32'd0);
    chk("rst_data", 32'(bus.tx_data), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_drop", 32'(drop_cnt), 32'd0);
    sys_rst_n = 1'b1;
    tick();

    // Latency and a two-digit string
    push(12'h045);
    chk("lat_n1", 32'(bus.tx_valid), 32'd0);
    tick();
    chk("lat_n2", 32'(bus.tx_valid), 32'd1);
    chk("s045_b0", 32'(bus.tx_data), 32'h34);
    tick();
    chk("s045_b1", 32'(bus.tx_data), 32'h35);
    tick();
    chk("s045_b2", 32'(bus.tx_data), 32'h0D);
    tick();
    chk("s045_b3", 32'(bus.tx_data), 32'h0A);
    tick();
    chk("s045_valid_end", 32'(bus.tx_valid), 32'd0);
    chk("s045_busy_end", 32'(busy), 32'd0);
    add_exp(12'h045);
    drain(1'b0);

    // Zero value then three digits, one idle cycle between strings
    seq = '{9'h030, 9'h00D, 9'h00A, 9'h100, 9'h032, 9'h030, 9'h035, 9'h00D, 9'h00A};
    push(12'h000);
    push(12'h205);
    wait_valid();
    for (int i = 0; i < 9; i++) begin
      if (seq[i][8]) begin
        chk($sformatf("gap_valid%0d", i), 32'(bus.tx_valid), 32'd0);
      end else begin
        chk($sformatf("seq_valid%0d", i), 32'(bus.tx_valid), 32'd1);
        chk($sformatf("seq_data%0d", i), 32'(bus.tx_data), 32'(seq[i][7:0]));
      end
      tick();
    end
    add_exp(12'h000);
    add_exp(12'h205);
    drain(1'b0);

    // Back-pressure on the second byte
    push(12'h123);
    wait_valid();
    chk("bp_b0", 32'(bus.tx_data), 32'h31);
    tick();
    chk("bp_b1", 32'(bus.tx_data), 32'h32);
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("bp_hold_valid", 32'(bus.tx_valid), 32'd1);
      chk("bp_hold_data", 32'(bus.tx_data), 32'h32);
    end
    bus.tx_ready = 1'b1;
    tick();
    chk("bp_b2", 32'(bus.tx_data), 32'h33);
    add_exp(12'h123);
    drain(1'b0);

    // Non-decimal tens nibble
    push(12'h0A7);
    add_exp(12'h0A7);
    drain(1'b0);

    // Overflow: one in flight, four queued, sixth push dropped
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 6; i++) vals[i] = 12'($urandom);
    for (int i = 0; i < 6; i++) push(vals[i]);
    for (int i = 0; i < 5; i++) add_exp(vals[i]);
    chk("ovf_drop", 32'(drop_cnt), 32'd1);
    chk("ovf_valid", 32'(bus.tx_valid), 32'd1);
    chk("ovf_first", 32'(bus.tx_data), 32'(exp_q[0]));
    chk("ovf_busy", 32'(busy), 32'd1);
    bus.tx_ready = 1'b1;
    drain(1'b0);

    // Reset mid-string with entries queued
    bus.tx_ready = 1'b0;
    push(12'h321);
    push(12'h654);
    push(12'h987);
    tick();
    chk("mid_busy", 32'(busy), 32'd1);
    chk("mid_valid", 32'(bus.tx_valid), 32'd1);
    sys_rst_n = 1'b0;
    tick();
    chk("mrst_valid", 32'(bus.tx_valid), 32'd0);
    chk("mrst_data", 32'(bus.tx_data), 32'h00);
    chk("mrst_drop", 32'(drop_cnt), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    sys_rst_n    = 1'b1;
    bus.tx_ready = 1'b1;
    repeat (10) tick();
    chk("mrst_no_bytes", 32'(got_q.size()), 32'd0);
    chk("mrst_idle", 32'(bus.tx_valid), 32'd0);
    got_q.delete();

    // Randomized bursts that fit without loss, random back-pressure
    for (int it = 0; it < 25; it++) begin
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        v = 12'($urandom);
        bus.tx_ready = 1'($urandom_range(0, 1));
        push(v);
        add_exp(v);
      end
      drain(1'b1);
      chk("rnd_drop", 32'(drop_cnt), 32'd0);
    end

    // Drop counter saturation
    bus.tx_ready = 1'b0;
    for (int i = 0; i < 265; i++) begin
      v = 12'($urandom);
      push(v);
      if (i < 5) add_exp(v);
    end
    chk("sat_drop", 32'(drop_cnt), 32'd255);
    chk("sat_busy", 32'(busy), 32'd1);
    bus.tx_ready = 1'b1;
    drain(1'b0);
    chk("sat_hold", 32'(drop_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
